// File: rtl/n2r_sched_pkg.sv
// Shared state encoding and size helpers for the normal-to-ready matmul scheduler.
package n2r_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FILL       = 3'd1,
    S_WAIT_SLICE = 3'd2,
    S_ISSUE      = 3'd3,
    S_DONE       = 3'd4
  } sched_state_t;

  function automatic int unsigned calc_chunks(input int unsigned col, input int unsigned bs);
    return col / bs;
  endfunction

  function automatic int unsigned calc_slices(input int unsigned row, input int unsigned bs,
                                              input int unsigned cores);
    return row / (bs * cores);
  endfunction

  // Counters never collapse to zero width, even for a single-entry range.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_counter.sv
// Wrap-at-limit counter with synchronous clear (priority) and increment.
module sched_counter #(
  parameter int unsigned LIMIT = 2,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  assign term = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= term ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/n2r_matmul_sched.sv
// Sequences row fill, per-slice buffer hand-off and chunk issue to the matmul core array.
module n2r_matmul_sched
  import n2r_sched_pkg::*;
#(
  parameter int unsigned ROW        = 8,
  parameter int unsigned COL        = 8,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned NUM_CORES  = 2,
  localparam int unsigned CHUNKS    = calc_chunks(COL, BLOCK_SIZE),
  localparam int unsigned SLICES    = calc_slices(ROW, BLOCK_SIZE, NUM_CORES),
  localparam int unsigned RW        = cnt_width(ROW),
  localparam int unsigned CW        = cnt_width(CHUNKS),
  localparam int unsigned SW        = cnt_width(SLICES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          row_valid,
  output logic          row_ready,
  output logic          buf_en,
  input  logic          buf_output_ready,
  input  logic          buf_slice_done,
  input  logic          buf_buffer_done,
  output logic          core_valid,
  input  logic          core_ready,
  output logic [CW-1:0] core_chunk_idx,
  output logic [SW-1:0] core_slice_idx,
  output logic          core_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  sched_state_t  state;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] chunk_cnt;
  logic [SW-1:0] slice_cnt;
  logic          row_term, chunk_term, slice_term;

  logic start_hit, abort_hit, cnt_clr;
  logic row_hs, chunk_hs;
  logic row_inc, chunk_inc, chunk_clr, slice_inc;
  logic err_set;

  always_comb begin
    start_hit = start & (state == S_IDLE);
    abort_hit = abort & (state != S_IDLE);
    cnt_clr   = start_hit | abort_hit;
    row_hs    = (state == S_FILL) & row_valid;
    chunk_hs  = (state == S_ISSUE) & core_ready;
    row_inc   = row_hs;
    chunk_inc = chunk_hs;
    chunk_clr = cnt_clr | (state == S_WAIT_SLICE);
    // Slice index holds at its last value through DONE so a late buffer_done is not flagged.
    slice_inc = chunk_hs & chunk_term & ~slice_term;
    err_set   = (state != S_IDLE) &
                (((state == S_ISSUE) & buf_slice_done & ~chunk_term) |
                 (buf_buffer_done & ~slice_term));
  end

  sched_counter #(.LIMIT(ROW), .W(RW)) u_row_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (row_inc),
    .cnt (row_cnt),
    .term(row_term)
  );

  sched_counter #(.LIMIT(CHUNKS), .W(CW)) u_chunk_cnt (
    .clk (clk),
    .rst (rst),
    .clr (chunk_clr),
    .inc (chunk_inc),
    .cnt (chunk_cnt),
    .term(chunk_term)
  );

  sched_counter #(.LIMIT(SLICES), .W(SW)) u_slice_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (slice_inc),
    .cnt (slice_cnt),
    .term(slice_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      err   <= 1'b0;
    end else begin
      if (start_hit) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end

      if (abort_hit) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE:       if (start) state <= S_FILL;
          S_FILL:       if (row_hs && row_term) state <= S_WAIT_SLICE;
          S_WAIT_SLICE: if (buf_output_ready) state <= S_ISSUE;
          S_ISSUE: begin
            if (chunk_hs && chunk_term) begin
              state <= slice_term ? S_DONE : S_WAIT_SLICE;
            end
          end
          S_DONE:       state <= S_IDLE;
          default:      state <= S_IDLE;
        endcase
      end
    end
  end

  assign row_ready      = (state == S_FILL);
  assign buf_en         = (state == S_FILL) | (state == S_WAIT_SLICE) | (state == S_ISSUE);
  assign core_valid     = (state == S_ISSUE);
  assign core_chunk_idx = chunk_cnt;
  assign core_slice_idx = slice_cnt;
  assign core_last      = core_valid & chunk_term & slice_term;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

endmodule
